// File: rtl/qualidade_pkg.sv
// Shared types and LED codes for the colour-quality inspection station.
package qualidade_pkg;

    typedef enum logic [1:0] {
        REPOUSO,
        AVALIACAO,
        AVALIADO,
        ERRO
    } estado_t;

    localparam logic [1:0] LED_OFF      = 2'b00;
    localparam logic [1:0] LED_VERDE    = 2'b01;
    localparam logic [1:0] LED_VERMELHO = 2'b10;
    localparam logic [1:0] LED_ERRO     = 2'b11;

endpackage

// File: rtl/contador_sat.sv
// Saturating up-counter with synchronous clear; reset and clear beat increment.
module contador_sat #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (inc && (q != '1)) begin
            q <= q + W'(1);
        end
    end

endmodule

// File: rtl/qualidade_param.sv
// Per-item colour inspection: majority vote over N_AMOSTRAS samples with a timeout,
// plus saturating approved/rejected/error statistics.
module qualidade_param
    import qualidade_pkg::*;
#(
    parameter int N_AMOSTRAS     = 3,
    parameter int TIMEOUT_CICLOS = 16,
    parameter int CNT_W          = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             presenca,
    input  logic             rgb,
    input  logic             rgb_valido,
    input  logic             clr_cnt,
    output logic [1:0]       leds,
    output logic             fim,
    output logic [CNT_W-1:0] cnt_aprov,
    output logic [CNT_W-1:0] cnt_reprov,
    output logic [CNT_W-1:0] cnt_erro
);

    localparam int AM_W = $clog2(N_AMOSTRAS + 1);
    localparam int TO_W = $clog2(TIMEOUT_CICLOS);
    localparam logic [AM_W-1:0] AM_ULT  = AM_W'(N_AMOSTRAS - 1);
    localparam logic [AM_W-1:0] MAIORIA = AM_W'(N_AMOSTRAS / 2);
    localparam logic [TO_W-1:0] TO_ULT  = TO_W'(TIMEOUT_CICLOS - 1);

    estado_t         estado, estado_nxt;
    logic [AM_W-1:0] amostras, amostras_nxt;
    logic [AM_W-1:0] uns, uns_nxt, uns_fim;
    logic [TO_W-1:0] tmo, tmo_nxt;
    logic [1:0]      leds_nxt;
    logic            fim_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            estado   <= REPOUSO;
            amostras <= '0;
            uns      <= '0;
            tmo      <= '0;
            leds     <= LED_OFF;
            fim      <= 1'b0;
        end else begin
            estado   <= estado_nxt;
            amostras <= amostras_nxt;
            uns      <= uns_nxt;
            tmo      <= tmo_nxt;
            leds     <= leds_nxt;
            fim      <= fim_nxt;
        end
    end

    always_comb begin
        estado_nxt   = estado;
        amostras_nxt = amostras;
        uns_nxt      = uns;
        tmo_nxt      = tmo;
        leds_nxt     = leds;
        fim_nxt      = 1'b0;
        // ones count including the sample offered this cycle
        uns_fim      = uns + AM_W'(rgb);

        case (estado)
            REPOUSO: begin
                leds_nxt = LED_OFF;
                if (presenca) begin
                    estado_nxt   = AVALIACAO;
                    amostras_nxt = '0;
                    uns_nxt      = '0;
                    tmo_nxt      = '0;
                end
            end
            AVALIACAO: begin
                leds_nxt = LED_OFF;
                if (!presenca) begin
                    estado_nxt = REPOUSO;
                end else if (rgb_valido && (amostras == AM_ULT)) begin
                    // final sample outranks a coincident timeout
                    estado_nxt = AVALIADO;
                    fim_nxt    = 1'b1;
                    leds_nxt   = (uns_fim > MAIORIA) ? LED_VERDE : LED_VERMELHO;
                end else if (tmo == TO_ULT) begin
                    estado_nxt = ERRO;
                    fim_nxt    = 1'b1;
                    leds_nxt   = LED_ERRO;
                end else begin
                    tmo_nxt = tmo + TO_W'(1);
                    if (rgb_valido) begin
                        amostras_nxt = amostras + AM_W'(1);
                        uns_nxt      = uns_fim;
                    end
                end
            end
            AVALIADO, ERRO: begin
                if (!presenca) begin
                    estado_nxt = REPOUSO;
                    leds_nxt   = LED_OFF;
                end
            end
            default: begin
                estado_nxt = REPOUSO;
                leds_nxt   = LED_OFF;
            end
        endcase
    end

    logic inc_aprov, inc_reprov, inc_erro;
    assign inc_aprov  = fim && (leds == LED_VERDE);
    assign inc_reprov = fim && (leds == LED_VERMELHO);
    assign inc_erro   = fim && (leds == LED_ERRO);

    contador_sat #(.W(CNT_W)) u_cnt_aprov (
        .clk (clk),
        .rst (rst),
        .clr (clr_cnt),
        .inc (inc_aprov),
        .q   (cnt_aprov)
    );

    contador_sat #(.W(CNT_W)) u_cnt_reprov (
        .clk (clk),
        .rst (rst),
        .clr (clr_cnt),
        .inc (inc_reprov),
        .q   (cnt_reprov)
    );

    contador_sat #(.W(CNT_W)) u_cnt_erro (
        .clk (clk),
        .rst (rst),
        .clr (clr_cnt),
        .inc (inc_erro),
        .q   (cnt_erro)
    );

endmodule

// File: tb/tb_qualidade_param.sv
// Scoreboard bench: expected verdict codes queued at stimulus, checked on each fim pulse.
module tb_qualidade_param;

    logic       clk = 1'b0;
    logic       rst, presenca, rgb, rgb_valido, clr_cnt;
    logic [1:0] leds;
    logic       fim;
    logic [3:0] cnt_aprov, cnt_reprov, cnt_erro;

    int         n_chk = 0;
    int         n_err = 0;
    logic [1:0] sb[$];

    qualidade_param #(
        .N_AMOSTRAS     (3),
        .TIMEOUT_CICLOS (16),
        .CNT_W          (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .presenca   (presenca),
        .rgb        (rgb),
        .rgb_valido (rgb_valido),
        .clr_cnt    (clr_cnt),
        .leds       (leds),
        .fim        (fim),
        .cnt_aprov  (cnt_aprov),
        .cnt_reprov (cnt_reprov),
        .cnt_erro   (cnt_erro)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_cnt(input int a, input int r, input int e);
        check("cnt_aprov", cnt_aprov, a);
        check("cnt_reprov", cnt_reprov, r);
        check("cnt_erro", cnt_erro, e);
    endtask

    // One item with samples s[0], s[1], s[2]; optional clr_cnt during the fim cycle.
    task automatic run_item(input logic [2:0] s, input bit clr_fim);
        logic [1:0] exp;
        exp = ($countones(s) >= 2) ? 2'b01 : 2'b10;
        presenca = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) begin
            rgb_valido = 1'b1;
            rgb        = s[i];
            if (i == 2) sb.push_back(exp);
            tick();
            rgb_valido = 1'b0;
            rgb        = 1'b0;
            if (i < 2) tick();
        end
        check("leds_verdict", leds, exp);
        check("fim_verdict", fim, 1);
        clr_cnt  = clr_fim;
        presenca = 1'b0;
        tick();
        clr_cnt = 1'b0;
        check("leds_idle", leds, 0);
    endtask

    always @(negedge clk) begin : monitor
        logic [1:0] e;
        if (fim === 1'b1) begin
            if (sb.size() == 0) begin
                check("fim_unexpected", fim, 0);
            end else begin
                e = sb.pop_front();
                check("fim_leds", leds, e);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; presenca = 1'b0; rgb = 1'b0; rgb_valido = 1'b0; clr_cnt = 1'b0;
        tick();
        tick();
        check("rst_leds", leds, 0);
        check("rst_fim", fim, 0);
        check_cnt(0, 0, 0);
        rst = 1'b0;
        tick();

        // approve and reject
        run_item(3'b101, 1'b0);
        check_cnt(1, 0, 0);
        run_item(3'b100, 1'b0);
        check_cnt(1, 1, 0);

        // timeout: 16 evaluation cycles with no samples
        presenca = 1'b1;
        tick();
        repeat (15) tick();
        check("leds_eval", leds, 0);
        sb.push_back(2'b11);
        tick();
        check("leds_err", leds, 3);
        repeat (3) tick();
        check("leds_err_hold", leds, 3);
        presenca = 1'b0;
        tick();
        check("leds_err_idle", leds, 0);
        check_cnt(1, 1, 1);

        // final sample on the timeout cycle gives a verdict
        presenca = 1'b1;
        tick();
        rgb_valido = 1'b1; rgb = 1'b1;
        tick();
        tick();
        rgb_valido = 1'b0; rgb = 1'b0;
        repeat (13) tick();
        rgb_valido = 1'b1; rgb = 1'b0;
        sb.push_back(2'b01);
        tick();
        rgb_valido = 1'b0;
        check("leds_coincide", leds, 1);
        presenca = 1'b0;
        tick();
        check_cnt(2, 1, 1);

        // abort after two samples; next item must start fresh
        presenca = 1'b1;
        tick();
        rgb_valido = 1'b1; rgb = 1'b1;
        tick();
        tick();
        rgb_valido = 1'b0; rgb = 1'b0;
        presenca = 1'b0;
        tick();
        check("leds_abort", leds, 0);
        tick();
        check_cnt(2, 1, 1);
        run_item(3'b100, 1'b0);
        check_cnt(2, 2, 1);

        // saturation, then clear coincident with a verdict
        for (int k = 0; k < 15; k++) run_item(3'b011, 1'b0);
        check_cnt(15, 2, 1);
        run_item(3'b111, 1'b1);
        check_cnt(0, 0, 0);

        // reset mid-evaluation, held together with clr_cnt
        run_item(3'b101, 1'b0);
        check_cnt(1, 0, 0);
        presenca = 1'b1;
        tick();
        rgb_valido = 1'b1; rgb = 1'b1;
        tick();
        tick();
        rgb_valido = 1'b0; rgb = 1'b0;
        rst = 1'b1;
        tick();
        check("rst_mid_leds", leds, 0);
        check("rst_mid_fim", fim, 0);
        check_cnt(0, 0, 0);
        clr_cnt = 1'b1;
        tick();
        check("rst_hold_leds", leds, 0);
        rst = 1'b0;
        clr_cnt = 1'b0;
        run_item(3'b011, 1'b0);
        check_cnt(1, 0, 0);

        tick();
        tick();
        check("sb_drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end

endmodule
